// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving two req/ack masters access to the
// single-port data memory, with byte-address to word-index translation and
// out-of-range / misaligned access rejection.
module dmem_arbiter #(
    parameter logic [31:0] ADDR_BASE  = 32'h10010000,
    parameter int unsigned DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [31:0]           m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic [31:0]           m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [31:0]           m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic [31:0]           m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  dm_r,
    output logic                  dm_w,
    output logic [DEPTH_LOG2-1:0] dm_addr,
    output logic [31:0]           dm_wdata,
    input  logic [31:0]           dm_rdata,
    output logic                  grant
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q;
    logic                  bad_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DW-1:0]         wdata_q;
    logic                  grant_q;
    logic                  last_q;
    logic [DW-1:0]         resp_q;
    logic                  m0_ack_q, m1_ack_q;
    logic                  m0_err_q, m1_err_q;

    logic                  any_req_c;
    logic                  win_c;
    logic                  sel_we_c;
    logic [DW-1:0]         sel_addr_c;
    logic [DW-1:0]         sel_wdata_c;
    logic [DW-1:0]         off_c;
    logic [DW-1:0]         word_c;
    logic                  bad_c;

    // Round-robin winner selection and address check of the request being latched
    always_comb begin
        any_req_c   = m0_req | m1_req;
        win_c       = (m0_req & m1_req) ? ~last_q : m1_req;
        sel_we_c    = win_c ? m1_we    : m0_we;
        sel_addr_c  = win_c ? m1_addr  : m0_addr;
        sel_wdata_c = win_c ? m1_wdata : m0_wdata;
        off_c       = sel_addr_c - ADDR_BASE;
        word_c      = off_c >> 2;
        bad_c       = (sel_addr_c < ADDR_BASE)
                    | (sel_addr_c[1:0] != 2'b00)
                    | ((word_c >> DEPTH_LOG2) != 32'd0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transaction is IDLE -> ACCESS -> RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes decoded from the state register so reset kills them at once
    always_comb begin
        dm_r = 1'b0;
        dm_w = 1'b0;
        if (state_q == ACCESS && !bad_q) begin
            dm_r = ~we_q;
            dm_w = we_q;
        end
    end

    // Request latch, round-robin pointer, read capture and ack/err generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            bad_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            resp_q   <= '0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_c) begin
                        we_q    <= sel_we_c;
                        bad_q   <= bad_c;
                        idx_q   <= word_c[DEPTH_LOG2-1:0];
                        wdata_q <= sel_wdata_c;
                        grant_q <= win_c;
                        last_q  <= win_c;
                    end
                end
                ACCESS: begin
                    resp_q   <= (!bad_q && !we_q) ? dm_rdata : '0;
                    m0_ack_q <= ~grant_q;
                    m1_ack_q <= grant_q;
                    m0_err_q <= ~grant_q & bad_q;
                    m1_err_q <= grant_q & bad_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign dm_addr  = idx_q;
    assign dm_wdata = wdata_q;
    assign grant    = grant_q;
    assign m0_rdata = resp_q;
    assign m1_rdata = resp_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 2048-word dmem.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        dm_r, dm_w;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        grant;

    int errors;
    int checks;

    logic [31:0] mem [0:2047];

    dmem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .dm_r     (dm_r),
        .dm_w     (dm_w),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .grant    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmem: combinational read, write on rising edge
    assign dm_rdata = dm_r ? mem[dm_addr] : 32'h0;
    always @(posedge clk) begin
        if (dm_w === 1'b1) mem[dm_addr] = dm_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction from the IDLE cycle through the following IDLE cycle
    task automatic txn(input logic m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata, input logic [10:0] exp_idx);
        logic exp_dmw;
        logic exp_dmr;
        exp_dmw = we & ~exp_err;
        exp_dmr = ~we & ~exp_err;
        if (m == 1'b0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        step();
        check("access_grant", 32'(grant), 32'(m));
        check("access_dm_w", 32'(dm_w), 32'(exp_dmw));
        check("access_dm_r", 32'(dm_r), 32'(exp_dmr));
        if (!exp_err) check("access_dm_addr", 32'(dm_addr), 32'(exp_idx));
        if (exp_dmw) check("access_dm_wdata", dm_wdata, wdata);
        check("access_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
        step();
        check("resp_dm_strobes", 32'({dm_r, dm_w}), 32'd0);
        if (m == 1'b0) begin
            check("resp_m0_ack", 32'(m0_ack), 32'd1);
            check("resp_m1_ack", 32'(m1_ack), 32'd0);
            check("resp_m0_err", 32'(m0_err), 32'(exp_err));
            check("resp_m0_rdata", m0_rdata, exp_rdata);
        end else begin
            check("resp_m1_ack", 32'(m1_ack), 32'd1);
            check("resp_m0_ack", 32'(m0_ack), 32'd0);
            check("resp_m1_err", 32'(m1_err), 32'(exp_err));
            check("resp_m1_rdata", m1_rdata, exp_rdata);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        check("idle_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
    endtask

    initial begin
        logic [11:0] e0;
        logic [11:0] e1;
        logic [11:0] eg;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'hA5000000 | 32'(i);

        // Reset state
        step();
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        check("rst_errs", 32'({m0_err, m1_err}), 32'd0);
        check("rst_strobes", 32'({dm_r, dm_w}), 32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        rst = 1'b0;

        // Master 0 write then read back
        txn(1'b0, 1'b1, 32'h10010008, 32'hDEADBEEF, 1'b0, 32'h0, 11'd2);
        txn(1'b0, 1'b0, 32'h10010008, 32'h0, 1'b0, 32'hDEADBEEF, 11'd2);

        // Master 1 good write and read in the middle of the array
        txn(1'b1, 1'b1, 32'h10011000, 32'h0BADF00D, 1'b0, 32'h0, 11'd1024);
        txn(1'b1, 1'b0, 32'h10011000, 32'h0, 1'b0, 32'h0BADF00D, 11'd1024);

        // Master 1 below base and one past the end
        txn(1'b1, 1'b0, 32'h1000FFFC, 32'h0, 1'b1, 32'h0, 11'd0);
        txn(1'b1, 1'b1, 32'h10012000, 32'h55555555, 1'b1, 32'h0, 11'd0);

        // Misaligned write must leave memory untouched
        txn(1'b0, 1'b1, 32'h10010006, 32'h77777777, 1'b1, 32'h0, 11'd0);
        txn(1'b0, 1'b0, 32'h10010004, 32'h0, 1'b0, 32'hA5000001, 11'd1);

        // First and last word, back to back
        txn(1'b0, 1'b0, 32'h10010000, 32'h0, 1'b0, 32'hA5000000, 11'd0);
        txn(1'b0, 1'b0, 32'h10011FFC, 32'h0, 1'b0, 32'hA50007FF, 11'd2047);

        // Reset in the middle of an ACCESS write
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10010010; m0_wdata = 32'hCAFEF00D;
        step();
        check("abort_dm_w_before", 32'(dm_w), 32'd1);
        check("abort_dm_addr", 32'(dm_addr), 32'd4);
        #3;
        rst = 1'b1;
        #1;
        check("abort_dm_w_killed", 32'(dm_w), 32'd0);
        check("abort_grant", 32'(grant), 32'd0);
        m0_req = 1'b0;
        step();
        rst = 1'b0;
        check("abort_no_ack0", 32'({m0_ack, m1_ack}), 32'd0);
        step();
        check("abort_no_ack1", 32'({m0_ack, m1_ack}), 32'd0);
        txn(1'b0, 1'b0, 32'h10010010, 32'h0, 1'b0, 32'hA5000004, 11'd4);

        // Both masters requesting continuously from reset
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10010008;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10010010;
        step();
        rst = 1'b0;
        e0 = 12'b0001_0000_0100;
        e1 = 12'b1000_0010_0000;
        eg = 12'b1100_0011_0000;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("rr_m0_ack_c%0d", c), 32'(m0_ack), 32'(e0[c]));
            check($sformatf("rr_m1_ack_c%0d", c), 32'(m1_ack), 32'(e1[c]));
            if ((c % 3) != 0) check($sformatf("rr_grant_c%0d", c), 32'(grant), 32'(eg[c]));
            if (e0[c]) check($sformatf("rr_m0_rdata_c%0d", c), m0_rdata, 32'hDEADBEEF);
            if (e1[c]) check($sformatf("rr_m1_rdata_c%0d", c), m1_rdata, 32'hA5000004);
            if (c == 11) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            step();
        end
        check("rr_idle_no_ack", 32'({m0_ack, m1_ack}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory (2048 x 32-bit words, byte base 0x10010000) between two bus masters: master 0 (CPU data port) and master 1 (debug/DMA loader). Each master uses a req/ack handshake. The arbiter registers the winning request, drives one dmem access cycle, and returns an ack with read data or an error flag. It sits between the masters and `dmem`, and performs the byte-address-to-word-index mapping that is currently done inline at the top level.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h10010000: byte address of dmem word 0.
- `DEPTH_LOG2`, default 11: log2 of the dmem word count; also the width of `dm_addr`.

Ports:
- `clk`  in  1  : the single clock; all state updates on its rising edge.
- `rst`  in  1  : asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1 each : request; held high until the matching ack.
- `m0_we`, `m1_we`  in  1 each : 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32 each : byte address.
- `m0_wdata`, `m1_wdata`  in  32 each : write data.
- `m0_rdata`, `m1_rdata`  out  32 each : read data; valid while the matching ack is high.
- `m0_ack`, `m1_ack`  out  1 each : one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1 each : error qualifier; valid with ack.
- `dm_r`, `dm_w`  out  1 each : dmem read and write strobes.
- `dm_addr`  out  DEPTH_LOG2 : dmem word index.
- `dm_wdata`  out  32 : dmem write data.
- `dm_rdata`  in  32 : dmem read data; combinational from `dm_addr`/`dm_r`.
- `grant`  out  1 : index of the master currently being served; valid outside IDLE.

## Operation
- FSM states are IDLE, ACCESS and RESP. Every transaction takes exactly three cycles: IDLE, then ACCESS, then RESP.
- IDLE
  - If any req is high, pick a winner and latch its we, addr and wdata into internal registers.
  - Set `grant` and go to ACCESS. Otherwise stay in IDLE.
- Arbitration is round-robin using a `last` pointer.
  - If only one req is high, that master wins.
  - If both are high, the master not equal to `last` wins.
  - `last` updates to the winner on the IDLE->ACCESS transition. Reset value of `last` is 1, so master 0 wins the first tie.
- Address check is done in IDLE on the latched request. `bad` = addr < ADDR_BASE, or addr[1:0] != 0, or ((addr - ADDR_BASE) >> 2) >= 2^DEPTH_LOG2.
- Word index: `dm_addr` = ((addr - ADDR_BASE) >> 2) truncated to DEPTH_LOG2 bits. The subtraction is done in 32 bits.
- ACCESS
  - If not `bad`: drive `dm_addr` and `dm_wdata` from the registers. Assert `dm_w` = we and `dm_r` = !we for the whole cycle.
  - If `bad`: `dm_r` = `dm_w` = 0, so no memory side effect.
  - Capture `dm_rdata` into the response register if this is a good read; otherwise capture 0.
  - Go to RESP.
- RESP
  - Assert ack for the granted master only. Drive its rdata from the response register and its err = `bad`.
  - The other master's ack/err stay 0. Go to IDLE.
- The master drops req or presents a new request in the cycle after ack.
  - A req that is still high in the following IDLE cycle is treated as a new transaction.
  - Round-robin then favours the other master if both are requesting.
- Requests that change while not in IDLE are ignored. The arbiter uses only the values latched in IDLE.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, `last` = 1, `grant` = 0.
  - All acks, errs, `dm_r`, `dm_w` = 0.
  - `dm_addr`, `dm_wdata`, rdata outputs = 0.
- `dm_r`/`dm_w` are decoded from the state register. An asserted `rst` therefore kills an in-flight ACCESS write strobe in the same cycle.
- Latency from req sampled in IDLE (cycle N) to ack is cycle N+2. Maximum throughput is one transaction per 3 cycles.
- Worst-case wait with both masters continuously requesting is 6 cycles from req to ack. Starvation is impossible.
- `dm_*` outputs are stable for the entire ACCESS cycle, so dmem may write on either clock edge within it.
- ack is high for exactly one cycle per transaction and never for both masters in the same cycle.
- If `rst` rises in ACCESS or RESP, the transaction is dropped with no ack. The master must reissue it.

## Test plan
- Master 0 writes 0xDEADBEEF to 0x10010008, then reads it back -> write: `dm_w`=1 with `dm_addr`=2 in the ACCESS cycle. Read: `m0_ack` at N+2 with `m0_rdata`=0xDEADBEEF and `m0_err`=0.
- Both reqs held high from reset for 4 transactions -> grants in order 0,1,0,1; acks at cycles 2, 5, 8, 11; never two acks in the same cycle.
- Master 1 reads 0x1000FFFC (below base) and writes 0x10012000 (index 2048) -> both ack with `m1_err`=1 and rdata=0; `dm_r`/`dm_w` never asserted.
- Master 0 writes to 0x10010006 (misaligned) -> `m0_err`=1, no `dm_w` pulse, memory contents unchanged.
- `rst` asserted mid-ACCESS of a write -> `dm_w` drops the same cycle, no ack, FSM in IDLE. A subsequent read of that address returns the old value.
- Master 0 alone issues back-to-back reads of 0x10010000 and 0x10011FFC -> acks 3 cycles apart; `dm_addr` = 0, then 2047.
